uart_rx: RTL and testbench

Serial receiver for the 8-bit UART link. It accepts the frame our transmitter emits: start bit 0, 8 data bits LSB first, even-parity bit (XOR of the data bits), stop bit 1. It oversamples the line with a 16x baud tick, delivers each byte with a one-cycle valid strobe, and flags parity and framing errors. It sits between the pad-side `rx` line and the byte-consuming logic, sharing the baud generator with the transmitter.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver for 8N1 / 8E1 frames.
//   Frame: start 0, 8 data bits LSB first, optional even-parity bit, stop 1.
//   Optional feature macro: UART_RX_PARITY_EN (defined -> 11-bit frame with
//   parity check; undefined -> 10-bit frame, parity_err tied to 0).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   os_tick    in   16x baud enable pulse, one clk wide
//   rx         in   asynchronous serial line, idles high
//   data       out  last received byte, held until the next valid
//   valid      out  one-cycle strobe when data is updated
//   parity_err out  parity mismatch of the last frame (updates with valid)
//   frame_err  out  stop bit sampled low in the last frame (updates with valid)
//   busy       out  high whenever the receiver is not idle
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(7);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(15);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t              state;
    logic                rx_m;
    logic                rx_s;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic                stop_bit;
    logic                stop_done;
`ifdef UART_RX_PARITY_EN
    logic                perr;
`endif

    // Synchronizer, bit timing, frame FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            stop_bit   <= 1'b1;
            stop_done  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
`endif
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            valid <= 1'b0;

            case (state)
                IDLE: begin
                    // Start detect runs every clk; a tick in this cycle is discarded.
                    if (!rx_s) begin
                        tick_cnt <= '0;
                        state    <= START;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (os_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            // Mid start bit: still low means a real frame.
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (os_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_LAST) begin
                            shift   <= {rx_s, shift[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_LAST) begin
                            perr  <= rx_s ^ (^shift);
                            state <= STOP;
                        end
                    end
                end
`endif

                STOP: begin
                    // Publish one clk after the stop sample, then return to IDLE
                    // mid stop bit so a back-to-back start edge is caught.
                    if (stop_done) begin
                        data       <= shift;
                        frame_err  <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
                        parity_err <= perr;
`else
                        parity_err <= 1'b0;
`endif
                        valid      <= 1'b1;
                        stop_done  <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else if (os_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_LAST) begin
                            stop_bit  <= rx_s;
                            stop_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven bench for uart_rx plus hand-written sequences for
// glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
    localparam int FRAME_PRE_STOP = 10;
`else
    localparam bit PEN = 1'b0;
    localparam int FRAME_PRE_STOP = 9;
`endif
    // Clocks from the edge that drops rx to the edge that raises valid.
    localparam int VALID_LAT = 4 * (16 * FRAME_PRE_STOP + 8) + 1;

    logic       clk;
    logic       rst;
    logic       os_tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .os_tick    (os_tick),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running 16x tick: one clk high every 4 clks.
    logic [1:0] tick_div = 2'd0;
    always @(posedge clk) tick_div <= tick_div + 2'd1;
    assign os_tick = (tick_div == 2'd3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Valid monitor: counts pulses, captures outputs on the strobe cycle.
    int         n_valid = 0;
    int         n_wide = 0;
    int         vcyc = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic       prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid  = n_valid + 1;
            vcyc     = cyc;
            cap_data = data;
            cap_perr = parity_err;
            cap_ferr = frame_err;
            if (prev_valid) n_wide = n_wide + 1;
        end
        prev_valid = (valid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns #1 after a clk edge at which os_tick was high.
    task automatic wait_tick();
        do @(negedge clk); while (os_tick !== 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int nticks);
        rx = b;
        for (int i = 0; i < nticks; i++) wait_tick();
    endtask

    int start_cyc = 0;

    // Caller must be aligned just after a tick edge.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int stop_ticks);
        start_cyc = cyc;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(b[i], 16);
        if (PEN) send_bit(p, 16);
        send_bit(s, stop_ticks);
        if (stop_ticks < 16) send_bit(1'b1, 16 - stop_ticks);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] byte_in;
        logic       par_bit;
        logic       stop_bit;
        int         stop_ticks;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0;
        // Stop-0 vector drops the line for only 10 ticks so the tail of a bad
        // stop bit cannot pass as a new start bit.
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 16, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 16, 8'h01, PEN,  1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 10, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 16, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 16, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 16, 8'h00, PEN,  1'b0};
        vecs[6] = '{8'h96, 1'b0, 1'b1, 16, 8'h96, 1'b0, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_perr", 32'(parity_err), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (4) wait_tick();

        // Table-driven single frames.
        for (int k = 0; k < 7; k++) begin
            nv0 = n_valid;
            send_frame(vecs[k].byte_in, vecs[k].par_bit, vecs[k].stop_bit, vecs[k].stop_ticks);
            repeat (16) wait_tick();
            check($sformatf("vec%0d_count", k), 32'(n_valid - nv0), 32'd1);
            check($sformatf("vec%0d_data", k), 32'(cap_data), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d_perr", k), 32'(cap_perr), 32'(vecs[k].exp_perr));
            check($sformatf("vec%0d_ferr", k), 32'(cap_ferr), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d_latency", k), 32'(vcyc - start_cyc), 32'(VALID_LAT));
            check($sformatf("vec%0d_busy_idle", k), 32'(busy), 32'h0);
        end

        // Glitch: rx low 4 ticks, then high.
        nv0 = n_valid;
        rx = 1'b0;
        repeat (2) wait_tick();
        check("glitch_busy_high", 32'(busy), 32'h1);
        repeat (2) wait_tick();
        rx = 1'b1;
        repeat (5) wait_tick();
        check("glitch_busy_low", 32'(busy), 32'h0);
        repeat (16) wait_tick();
        check("glitch_no_valid", 32'(n_valid - nv0), 32'd0);
        check("glitch_data_held", 32'(data), 32'h96);

        // Back-to-back frames, no idle gap.
        nv0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b1, 16);
        check("b2b0_data", 32'(cap_data), 32'h55);
        check("b2b0_err", 32'({cap_perr, cap_ferr}), 32'h0);
        send_frame(8'hAA, 1'b0, 1'b1, 16);
        repeat (8) wait_tick();
        check("b2b1_data", 32'(cap_data), 32'hAA);
        check("b2b1_err", 32'({cap_perr, cap_ferr}), 32'h0);
        check("b2b_count", 32'(n_valid - nv0), 32'd2);

        // Reset in the middle of data bit 3 of 0x5A.
        nv0 = n_valid;
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 8);
        check("rst_busy_before", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) wait_tick();
        check("rst_no_valid", 32'(n_valid - nv0), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'h0);
        send_frame(8'hF0, 1'b0, 1'b1, 16);
        repeat (8) wait_tick();
        check("post_rst_count", 32'(n_valid - nv0), 32'd1);
        check("post_rst_data", 32'(cap_data), 32'hF0);
        check("post_rst_err", 32'({cap_perr, cap_ferr}), 32'h0);
        check("post_rst_data_held", 32'(data), 32'hF0);

        check("valid_width", 32'(n_wide), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
